register_bus_unit: RTL and testbench

//  Parametrised register file plus data/address bus fabric for the relay computer datapath.

---
 rtl/relay_pkg.sv | 23 ++
 rtl/bus_or_mux.sv | 23 ++
 rtl/register_bus_unit.sv | 114 +++++++++++
 tb/tb_register_bus_unit.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/relay_pkg.sv
// Shared constants for the relay computer register/bus fabric: address-source
// request bit positions and the default general-register indices.
package relay_pkg;

  localparam int ADDR_SEL_M   = 0;
  localparam int ADDR_SEL_XY  = 1;
  localparam int ADDR_SEL_J   = 2;
  localparam int ADDR_SEL_PC  = 3;
  localparam int ADDR_SEL_INC = 4;
  localparam int NUM_ADDR_SRC = 5;

  typedef logic [NUM_ADDR_SRC-1:0] addr_sel_t;

  localparam int REG_A  = 0;
  localparam int REG_B  = 1;
  localparam int REG_C  = 2;
  localparam int REG_D  = 3;
  localparam int REG_M1 = 4;
  localparam int REG_M2 = 5;
  localparam int REG_X  = 6;
  localparam int REG_Y  = 7;

endpackage

// File: rtl/bus_or_mux.sv
// Wired-OR bus resolver: ORs every source whose valid bit is set and flags
// when more than one source is driving at once.
module bus_or_mux #(
  parameter int N = 2,
  parameter int W = 8
) (
  input  logic [N*W-1:0] src_i,
  input  logic [N-1:0]   valid_i,
  output logic [W-1:0]   bus_o,
  output logic           multi_o
);

  always_comb begin
    bus_o = '0;
    for (int i = 0; i < N; i++) begin
      if (valid_i[i]) bus_o = bus_o | src_i[i*W +: W];
    end
  end

  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi_o = |(valid_i & (valid_i - N'(1)));

endmodule

// File: rtl/register_bus_unit.sv
// Register file plus shared data/address bus fabric for the relay datapath,
// with sticky detection of multi-driver contention on either bus.
module register_bus_unit
  import relay_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 8,
  parameter int M_HI     = 4,
  parameter int XY_HI    = 6,
  parameter int ADDR_W   = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_REGS-1:0]        ld,
  input  logic [NUM_REGS-1:0]        sel,
  input  logic                       ext_sel,
  input  logic [DATA_W-1:0]          ext_data,
  input  logic [1:0]                 ld_j,
  input  logic                       ld_xy,
  input  logic                       ld_pc,
  input  logic                       ld_inc,
  input  addr_sel_t                  addr_sel,
  input  logic                       clr_err,
  output logic [DATA_W-1:0]          data_bus,
  output logic [ADDR_W-1:0]          addr_bus,
  output logic [NUM_REGS*DATA_W-1:0] regs_q,
  output logic [ADDR_W-1:0]          pc_q,
  output logic                       data_err,
  output logic                       addr_err
);

  if (ADDR_W != 2*DATA_W) begin : g_addr_w_check
    $error("register_bus_unit: ADDR_W must equal 2*DATA_W");
  end

  logic [DATA_W-1:0] reg_q [NUM_REGS];
  logic [DATA_W-1:0] j1_q, j2_q;
  logic [ADDR_W-1:0] inc_q;
  logic              data_err_q, data_err_d;
  logic              addr_err_q, addr_err_d;

  logic [(NUM_REGS+1)*DATA_W-1:0] data_src;
  logic [NUM_ADDR_SRC*ADDR_W-1:0] addr_src;
  logic [DATA_W-1:0]              data_or;
  logic [ADDR_W-1:0]              addr_or;
  logic                           data_multi, addr_multi;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
    assign regs_q[g*DATA_W +: DATA_W] = reg_q[g];
  end

  // External source sits just above the general registers in the data source list.
  assign data_src = {ext_data, regs_q};

  always_comb begin
    addr_src = '0;
    addr_src[ADDR_SEL_M*ADDR_W   +: ADDR_W] = {reg_q[M_HI], reg_q[M_HI+1]};
    addr_src[ADDR_SEL_XY*ADDR_W  +: ADDR_W] = {reg_q[XY_HI], reg_q[XY_HI+1]};
    addr_src[ADDR_SEL_J*ADDR_W   +: ADDR_W] = {j1_q, j2_q};
    addr_src[ADDR_SEL_PC*ADDR_W  +: ADDR_W] = pc_q;
    addr_src[ADDR_SEL_INC*ADDR_W +: ADDR_W] = inc_q;
  end

  bus_or_mux #(.N(NUM_REGS+1), .W(DATA_W)) u_data_mux (
    .src_i   (data_src),
    .valid_i ({ext_sel, sel}),
    .bus_o   (data_or),
    .multi_o (data_multi)
  );

  bus_or_mux #(.N(NUM_ADDR_SRC), .W(ADDR_W)) u_addr_mux (
    .src_i   (addr_src),
    .valid_i (addr_sel),
    .bus_o   (addr_or),
    .multi_o (addr_multi)
  );

  // The external source is not reset, so the buses are forced quiet during reset.
  assign data_bus = reset ? '0 : data_or;
  assign addr_bus = reset ? '0 : addr_or;

  assign data_err_d = (data_err_q & ~clr_err) | data_multi;
  assign addr_err_d = (addr_err_q & ~clr_err) | addr_multi;
  assign data_err   = data_err_q;
  assign addr_err   = addr_err_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) reg_q[i] <= '0;
      j1_q       <= '0;
      j2_q       <= '0;
      pc_q       <= '0;
      inc_q      <= '0;
      data_err_q <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (ld[i]) reg_q[i] <= data_bus;
      end
      // Later assignment wins: ld_xy overrides a data-bus load of X or Y.
      if (ld_xy) begin
        reg_q[XY_HI]   <= addr_bus[ADDR_W-1:DATA_W];
        reg_q[XY_HI+1] <= addr_bus[DATA_W-1:0];
      end
      if (ld_j[1]) j1_q <= data_bus;
      if (ld_j[0]) j2_q <= data_bus;
      if (ld_pc)   pc_q <= addr_bus;
      if (ld_inc)  inc_q <= addr_bus + ADDR_W'(1);
      data_err_q <= data_err_d;
      addr_err_q <= addr_err_d;
    end
  end

endmodule

// File: tb/tb_register_bus_unit.sv
// Self-checking bench for register_bus_unit: directed scenarios followed by
// randomized traffic, all compared against a behavioural model of the fabric.
module tb_register_bus_unit;

  logic        clk;
  logic        rst;
  logic [7:0]  ld;
  logic [7:0]  sel;
  logic        ext_sel;
  logic [7:0]  ext_data;
  logic [1:0]  ld_j;
  logic        ld_xy;
  logic        ld_pc;
  logic        ld_inc;
  logic [4:0]  addr_sel;
  logic        clr_err;
  logic [7:0]  data_bus;
  logic [15:0] addr_bus;
  logic [63:0] regs_q;
  logic [15:0] pc_q;
  logic        data_err;
  logic        addr_err;

  int n_total = 0;
  int n_bad   = 0;

  // Behavioural model state
  logic [7:0]  m_regs [8];
  logic [7:0]  m_j1, m_j2;
  logic [15:0] m_pc, m_inc;
  logic        m_derr, m_aerr;

  register_bus_unit dut (
    .clock    (clk),
    .reset    (rst),
    .ld       (ld),
    .sel      (sel),
    .ext_sel  (ext_sel),
    .ext_data (ext_data),
    .ld_j     (ld_j),
    .ld_xy    (ld_xy),
    .ld_pc    (ld_pc),
    .ld_inc   (ld_inc),
    .addr_sel (addr_sel),
    .clr_err  (clr_err),
    .data_bus (data_bus),
    .addr_bus (addr_bus),
    .regs_q   (regs_q),
    .pc_q     (pc_q),
    .data_err (data_err),
    .addr_err (addr_err)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- model ----------------
  function automatic logic [7:0] model_data_bus();
    logic [7:0] d = 8'h00;
    for (int i = 0; i < 8; i++) if (sel[i]) d = d | m_regs[i];
    if (ext_sel) d = d | ext_data;
    return d;
  endfunction

  function automatic logic [15:0] model_addr_bus();
    logic [15:0] a = 16'h0000;
    if (addr_sel[0]) a = a | {m_regs[4], m_regs[5]};
    if (addr_sel[1]) a = a | {m_regs[6], m_regs[7]};
    if (addr_sel[2]) a = a | {m_j1, m_j2};
    if (addr_sel[3]) a = a | m_pc;
    if (addr_sel[4]) a = a | m_inc;
    return a;
  endfunction

  function automatic logic [63:0] model_flat();
    logic [63:0] f;
    for (int i = 0; i < 8; i++) f[i*8 +: 8] = m_regs[i];
    return f;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
    m_j1 = 8'h00; m_j2 = 8'h00; m_pc = 16'h0000; m_inc = 16'h0000;
    m_derr = 1'b0; m_aerr = 1'b0;
  endtask

  task automatic model_clock();
    logic [7:0]  d;
    logic [15:0] a;
    int          nd, na;
    d  = model_data_bus();
    a  = model_addr_bus();
    nd = $countones(sel) + (ext_sel ? 1 : 0);
    na = $countones(addr_sel);
    for (int i = 0; i < 8; i++) if (ld[i]) m_regs[i] = d;
    if (ld_xy) begin
      m_regs[6] = a[15:8];
      m_regs[7] = a[7:0];
    end
    if (ld_j[1]) m_j1 = d;
    if (ld_j[0]) m_j2 = d;
    if (ld_pc)   m_pc = a;
    if (ld_inc)  m_inc = 16'((32'(a) + 1) % 65536);
    m_derr = (m_derr && !clr_err) || (nd > 1);
    m_aerr = (m_aerr && !clr_err) || (na > 1);
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle();
    ld = '0; sel = '0; ext_sel = 1'b0; ext_data = '0; ld_j = '0;
    ld_xy = 1'b0; ld_pc = 1'b0; ld_inc = 1'b0; addr_sel = '0; clr_err = 1'b0;
  endtask

  // Inputs are already applied just after a falling edge; check buses, clock once, check state.
  task automatic do_cycle(input string tag);
    #1;
    check({tag, ".data_bus"}, 64'(data_bus), 64'(model_data_bus()));
    check({tag, ".addr_bus"}, 64'(addr_bus), 64'(model_addr_bus()));
    @(posedge clk);
    model_clock();
    #1;
    check({tag, ".regs"}, regs_q, model_flat());
    check({tag, ".pc"}, 64'(pc_q), 64'(m_pc));
    check({tag, ".data_err"}, 64'(data_err), 64'(m_derr));
    check({tag, ".addr_err"}, 64'(addr_err), 64'(m_aerr));
    @(negedge clk);
  endtask

  task automatic load_reg(input int idx, input logic [7:0] val);
    idle();
    ext_sel = 1'b1; ext_data = val; ld[idx] = 1'b1;
    do_cycle("load");
  endtask

  task automatic apply_reset();
    @(negedge clk);
    idle();
    ext_sel = 1'b1; ext_data = 8'hC3; addr_sel = 5'b00001;
    #2 rst = 1'b1;
    model_reset();
    #1;
    check("rst.regs", regs_q, 64'h0);
    check("rst.pc", 64'(pc_q), 64'h0);
    check("rst.data_bus", 64'(data_bus), 64'h0);
    check("rst.addr_bus", 64'(addr_bus), 64'h0);
    check("rst.data_err", 64'(data_err), 64'h0);
    check("rst.addr_err", 64'(addr_err), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    idle();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1;
    idle();
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Build up some state, then reset mid-run
    load_reg(0, 8'h11);
    load_reg(4, 8'h22);
    idle(); sel = 8'h03; addr_sel = 5'b00011; ld_pc = 1'b1;
    do_cycle("prerst");
    apply_reset();

    // Transfer A <- ext, B <- A
    idle(); ext_sel = 1'b1; ext_data = 8'h5A; ld[0] = 1'b1;
    do_cycle("xfer1");
    check("xfer.A", 64'(regs_q[7:0]), 64'h5A);
    idle(); sel[0] = 1'b1; ld[1] = 1'b1;
    do_cycle("xfer2");
    check("xfer.B", 64'(regs_q[15:8]), 64'h5A);
    check("xfer.derr", 64'(data_err), 64'h0);

    // Address: M=1234 -> INC=1235 -> PC
    load_reg(4, 8'h12);
    load_reg(5, 8'h34);
    idle(); addr_sel = 5'b00001; ld_inc = 1'b1;
    #1 check("addr.M", 64'(addr_bus), 64'h1234);
    do_cycle("addr1");
    idle(); addr_sel = 5'b10000; ld_pc = 1'b1;
    #1 check("addr.INC", 64'(addr_bus), 64'h1235);
    do_cycle("addr2");
    check("addr.pc", 64'(pc_q), 64'h1235);

    // Wrap and ld_xy priority
    load_reg(6, 8'hFF);
    load_reg(7, 8'hFF);
    idle(); addr_sel = 5'b00010; ld_inc = 1'b1;
    do_cycle("wrap1");
    idle(); addr_sel = 5'b10000;
    #1 check("wrap.INC", 64'(addr_bus), 64'h0000);
    do_cycle("wrap2");
    idle(); ext_sel = 1'b1; ext_data = 8'hAB; ld_j = 2'b10;
    do_cycle("ldj1");
    idle(); ext_sel = 1'b1; ext_data = 8'hCD; ld_j = 2'b01;
    do_cycle("ldj2");
    idle(); addr_sel = 5'b00100; ld_xy = 1'b1; ld[6] = 1'b1; ext_sel = 1'b1; ext_data = 8'h77;
    do_cycle("xyprio");
    check("xy.X", 64'(regs_q[55:48]), 64'hAB);
    check("xy.Y", 64'(regs_q[63:56]), 64'hCD);

    // Data contention, sticky flag, clear, clear-vs-set
    load_reg(0, 8'h0F);
    load_reg(1, 8'hF0);
    idle(); sel = 8'h03; ld[2] = 1'b1;
    do_cycle("cont1");
    check("cont.C", 64'(regs_q[23:16]), 64'hFF);
    check("cont.derr", 64'(data_err), 64'h1);
    idle();
    do_cycle("hold");
    check("hold.derr", 64'(data_err), 64'h1);
    idle(); clr_err = 1'b1;
    do_cycle("clr");
    check("clr.derr", 64'(data_err), 64'h0);
    idle(); clr_err = 1'b1; sel = 8'h03;
    do_cycle("clrset");
    check("clrset.derr", 64'(data_err), 64'h1);

    // Address contention and empty-bus load
    idle(); addr_sel = 5'b11000;
    #1 check("acont.bus", 64'(addr_bus), 64'(16'h1235 | 16'h0000));
    do_cycle("acont");
    check("acont.aerr", 64'(addr_err), 64'h1);
    load_reg(3, 8'h99);
    idle(); ld[3] = 1'b1;
    do_cycle("nodrv");
    check("nodrv.D", 64'(regs_q[31:24]), 64'h00);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      idle();
      for (int i = 0; i < 8; i++) begin
        sel[i] = ($urandom_range(0, 9) == 0);
        ld[i]  = ($urandom_range(0, 3) == 0);
      end
      ext_sel  = ($urandom_range(0, 2) == 0);
      ext_data = 8'($urandom);
      ld_j     = 2'($urandom_range(0, 3));
      ld_xy    = ($urandom_range(0, 5) == 0);
      ld_pc    = ($urandom_range(0, 3) == 0);
      ld_inc   = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 5))
        0:       addr_sel = 5'b00000;
        1:       addr_sel = 5'($urandom);
        default: addr_sel = 5'(1 << $urandom_range(0, 4));
      endcase
      clr_err  = ($urandom_range(0, 7) == 0);
      do_cycle("rand");
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
